// File: rtl/mapache64_pkg.sv
// mapache64: shared VRAM types, background region bounds and scheduler state encoding
package mapache64;
    typedef logic [11:0] vram_address_t;
    typedef logic [7:0] data_t;
    localparam vram_address_t PMB_BASE = 12'h200;
    localparam vram_address_t PMB_END = 12'h3FF;
    localparam vram_address_t NTBL_BASE = 12'h400;
    localparam vram_address_t NTBL_END = 12'h7FF;
    typedef struct packed {
        vram_address_t address;
        data_t data;
    } vram_write_t;
    typedef enum logic {IDLE, DRAIN} sched_state_t;
    function automatic logic in_range(input vram_address_t a, input vram_address_t lo, input vram_address_t hi);
        return a >= lo && a <= hi;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; full/empty come from the registered level, so a push while full is refused even if a pop happens
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter type T = logic [7:0],
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T din,
    output T dout,
    output logic full,
    output logic empty,
    output logic [AW:0] level
);
    T mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    always_comb begin
        full = level == (AW+1)'(DEPTH);
        empty = level == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        dout = mem[rd_ptr];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: queues CPU background-VRAM writes and drains them only during vblank, yielding to CPU reads
module vram_write_scheduler
    import mapache64::*;
#(
    parameter int DEPTH = 16
) (
    input  logic cpu_clk,
    input  logic rst,
    input  logic vblank_i,
    input  logic cpu_read_i,
    input  logic cpu_wen_i,
    input  vram_address_t cpu_address_i,
    input  data_t cpu_wdata_i,
    output vram_address_t vram_address_o,
    output data_t vram_wdata_o,
    output logic vram_wen_o,
    output logic SELECT_pmb_o,
    output logic SELECT_ntbl_o,
    output logic full_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic busy_o,
    output logic overflow_o,
    input  logic overflow_clr_i
);
    sched_state_t state, state_next;
    vram_write_t head;
    logic push, pop, empty;
    logic [$clog2(DEPTH):0] level_next;
    sync_fifo #(.DEPTH(DEPTH), .T(vram_write_t)) u_fifo (
        .clk(cpu_clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din({cpu_address_i, cpu_wdata_i}),
        .dout(head),
        .full(full_o),
        .empty(empty),
        .level(level_o)
    );
    always_comb begin
        push = cpu_wen_i && in_range(cpu_address_i, PMB_BASE, NTBL_END);
        pop = state == DRAIN && vblank_i && !cpu_read_i && !empty;
        level_next = level_o + ($clog2(DEPTH)+1)'(push && !full_o) - ($clog2(DEPTH)+1)'(pop);
        state_next = state == IDLE ? (vblank_i && !empty ? DRAIN : IDLE)
                                   : (!vblank_i || level_next == '0 ? IDLE : DRAIN);
        vram_wen_o = pop;
        vram_address_o = pop ? head.address : cpu_address_i;
        vram_wdata_o = head.data;
        SELECT_pmb_o = in_range(vram_address_o, PMB_BASE, PMB_END);
        SELECT_ntbl_o = in_range(vram_address_o, NTBL_BASE, NTBL_END);
        busy_o = state == DRAIN;
    end
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            overflow_o <= 1'b0;
        end else begin
            state <= state_next;
            if (push && full_o) overflow_o <= 1'b1;
            else if (overflow_clr_i) overflow_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler: directed vectors for the vblank-gated VRAM write scheduler
module tb_vram_write_scheduler;
    logic cpu_clk = 1'b0;
    logic rst = 1'b1;
    logic vblank_i = 1'b0;
    logic cpu_read_i = 1'b0;
    logic cpu_wen_i = 1'b0;
    logic [11:0] cpu_address_i = '0;
    logic [7:0] cpu_wdata_i = '0;
    logic [11:0] vram_address_o;
    logic [7:0] vram_wdata_o;
    logic vram_wen_o, SELECT_pmb_o, SELECT_ntbl_o, full_o, busy_o, overflow_o;
    logic overflow_clr_i = 1'b0;
    logic [4:0] level_o;
    int n_cmp = 0;
    int n_err = 0;

    vram_write_scheduler #(.DEPTH(16)) dut (
        .cpu_clk(cpu_clk),
        .rst(rst),
        .vblank_i(vblank_i),
        .cpu_read_i(cpu_read_i),
        .cpu_wen_i(cpu_wen_i),
        .cpu_address_i(cpu_address_i),
        .cpu_wdata_i(cpu_wdata_i),
        .vram_address_o(vram_address_o),
        .vram_wdata_o(vram_wdata_o),
        .vram_wen_o(vram_wen_o),
        .SELECT_pmb_o(SELECT_pmb_o),
        .SELECT_ntbl_o(SELECT_ntbl_o),
        .full_o(full_o),
        .level_o(level_o),
        .busy_o(busy_o),
        .overflow_o(overflow_o),
        .overflow_clr_i(overflow_clr_i)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) begin
        assert (!(cpu_wen_i && cpu_read_i)) else $error("illegal cpu_wen_i with cpu_read_i");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        cpu_wen_i = 1'b1;
        cpu_address_i = a;
        cpu_wdata_i = d;
        cyc();
        cpu_wen_i = 1'b0;
        cpu_address_i = '0;
    endtask

    task automatic drain(input int n, input logic [11:0] a0, input logic [7:0] d0, input int budget);
        int got = 0;
        for (int k = 0; k < budget && got < n; k++) begin
            if (vram_wen_o) begin
                chk("drain_addr", vram_address_o, a0 + 12'(got));
                chk("drain_data", vram_wdata_o, d0 + 8'(got));
                got++;
            end
            cyc();
            #1;
        end
        chk("drain_count", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_level", level_o, 0);
        chk("rst_wen", vram_wen_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", overflow_o, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        wr(12'h400, 8'h12);
        wr(12'h7C0, 8'h3F);
        chk("t1_level", level_o, 2);
        chk("t1_idle_wen", vram_wen_o, 0);
        vblank_i = 1'b1;
        #1;
        chk("t1_first_wen", vram_wen_o, 0);
        cyc();
        #1;
        chk("t1_w0_wen", vram_wen_o, 1);
        chk("t1_w0_addr", vram_address_o, 12'h400);
        chk("t1_w0_data", vram_wdata_o, 8'h12);
        chk("t1_w0_ntbl", SELECT_ntbl_o, 1);
        cyc();
        #1;
        chk("t1_w1_wen", vram_wen_o, 1);
        chk("t1_w1_addr", vram_address_o, 12'h7C0);
        chk("t1_w1_data", vram_wdata_o, 8'h3F);
        chk("t1_w1_ntbl", SELECT_ntbl_o, 1);
        cyc();
        #1;
        chk("t1_end_wen", vram_wen_o, 0);
        chk("t1_end_busy", busy_o, 0);
        chk("t1_end_level", level_o, 0);
        vblank_i = 1'b0;

        for (int i = 0; i < 17; i++) begin
            wr(12'h200 + 12'(i), 8'(i));
            if (i == 15) begin
                chk("t2_full16", full_o, 1);
                chk("t2_level16", level_o, 16);
                chk("t2_noovf16", overflow_o, 0);
            end
        end
        chk("t2_ovf", overflow_o, 1);
        chk("t2_level17", level_o, 16);
        cpu_wen_i = 1'b1;
        cpu_address_i = 12'h210;
        overflow_clr_i = 1'b1;
        cyc();
        cpu_wen_i = 1'b0;
        overflow_clr_i = 1'b0;
        #1;
        chk("t2_set_wins", overflow_o, 1);
        overflow_clr_i = 1'b1;
        cyc();
        overflow_clr_i = 1'b0;
        #1;
        chk("t2_clr", overflow_o, 0);
        vblank_i = 1'b1;
        #1;
        drain(16, 12'h200, 8'h00, 40);
        vblank_i = 1'b0;
        chk("t2_level0", level_o, 0);
        chk("t2_full0", full_o, 0);

        for (int i = 0; i < 4; i++) wr(12'h300 + 12'(i), 8'hA0 + 8'(i));
        vblank_i = 1'b1;
        #1;
        cyc();
        #1;
        chk("t3_w0_wen", vram_wen_o, 1);
        chk("t3_w0_addr", vram_address_o, 12'h300);
        chk("t3_w0_data", vram_wdata_o, 8'hA0);
        cyc();
        cpu_read_i = 1'b1;
        cpu_address_i = 12'h205;
        #1;
        chk("t3_rd_wen", vram_wen_o, 0);
        chk("t3_rd_addr", vram_address_o, 12'h205);
        chk("t3_rd_pmb", SELECT_pmb_o, 1);
        chk("t3_rd_ntbl", SELECT_ntbl_o, 0);
        cyc();
        cpu_read_i = 1'b0;
        cpu_address_i = '0;
        #1;
        drain(3, 12'h301, 8'hA1, 3);
        vblank_i = 1'b0;

        for (int i = 0; i < 6; i++) wr(12'h400 + 12'(i), 8'h60 + 8'(i));
        vblank_i = 1'b1;
        #1;
        drain(3, 12'h400, 8'h60, 4);
        vblank_i = 1'b0;
        #1;
        chk("t4_low_wen", vram_wen_o, 0);
        cyc();
        #1;
        chk("t4_idle_busy", busy_o, 0);
        chk("t4_level3", level_o, 3);
        repeat (3) cyc();
        chk("t4_hold_level", level_o, 3);
        chk("t4_hold_wen", vram_wen_o, 0);
        vblank_i = 1'b1;
        #1;
        drain(3, 12'h403, 8'h63, 6);
        vblank_i = 1'b0;
        chk("t4_level0", level_o, 0);

        wr(12'h100, 8'h55);
        wr(12'h800, 8'h66);
        wr(12'h1FF, 8'h77);
        chk("t5_level", level_o, 0);
        chk("t5_ovf", overflow_o, 0);

        for (int i = 0; i < 5; i++) wr(12'h500 + 12'(i), 8'hC0 + 8'(i));
        vblank_i = 1'b1;
        #1;
        cyc();
        #1;
        chk("t6_pre_wen", vram_wen_o, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_wen", vram_wen_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_full", full_o, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t6_post_wen", vram_wen_o, 0);
        end
        chk("t6_post_level", level_o, 0);
        vblank_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Buffers CPU writes to background VRAM (PMB, NTBL) in a FIFO and drains them only while vblank_i is high, so the nametable and patterns never change mid-frame (no tearing).
- Sits between the CPU bus decode and the background VRAM port: it drives the background VRAM address, write data, write enable and the PMB/NTBL selects.
- Arbitrates the shared VRAM address between CPU reads (pass-through, highest priority) and its own drain writes.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
cpu_clk  input  1  system clock; all state on posedge
rst  input  1  asynchronous, active-high reset
vblank_i  input  1  high during vertical blanking; drain permitted
cpu_read_i  input  1  CPU VRAM read this cycle; has priority over drain
cpu_wen_i  input  1  CPU VRAM write request
cpu_address_i  input  mapache64::vram_address_t  CPU address (read or write)
cpu_wdata_i  input  mapache64::data_t  CPU write data
vram_address_o  output  mapache64::vram_address_t  address to background VRAM
vram_wdata_o  output  mapache64::data_t  write data to background VRAM
vram_wen_o  output  1  VRAM write strobe
SELECT_pmb_o  output  1  address in 0x200-0x3FF
SELECT_ntbl_o  output  1  address in 0x400-0x7FF
full_o  output  1  FIFO holds DEPTH entries
level_o  output  AW+1  current occupancy
busy_o  output  1  state is DRAIN
overflow_o  output  1  sticky: a write was dropped because the FIFO was full
overflow_clr_i  input  1  clears overflow_o

Behaviour:
- Reset (async): pointers=0, level_o=0, state=IDLE, overflow_o=0, vram_wen_o=0, full_o=0, busy_o=0.
- Entry = {address, data}. Enqueue when cpu_wen_i && address in 0x200-0x7FF && !full_o.
  - Out-of-range writes are ignored silently and do not set overflow.
- full_o is evaluated on the registered level before any same-cycle pop. A write arriving while full is dropped and sets overflow_o, even if a pop occurs in the same cycle.
- overflow_clr_i clears overflow_o. If a drop coincides with the clear, set wins.
- An entry enqueued in cycle N can first be popped in cycle N+1.
- FSM:
  - IDLE -> DRAIN when vblank_i && level_o!=0.
  - DRAIN -> IDLE when level_o becomes 0 after the pop, or when vblank_i is low.
  - A pending entry is never written while vblank_i is low; it remains queued and is drained in the next vblank.
- Pop condition (combinational): pop = state==DRAIN && vblank_i && !cpu_read_i && level_o!=0.
  - When pop is true: vram_wen_o=1, vram_address_o/vram_wdata_o = FIFO head, and the read pointer advances at posedge.
  - VRAM samples on negedge, so the head is stable for the whole high phase.
- Otherwise: vram_wen_o=0, vram_address_o=cpu_address_i (read pass-through), vram_wdata_o = head (don't-care).
- Drain throughput: one entry per cycle; each cpu_read_i stalls the drain for exactly one cycle.
- Selects are decoded from whatever vram_address_o currently carries:
  - pmb = address[11:9]==3'b001
  - ntbl = address[11:10]==2'b01
- Simultaneous push and pop: level unchanged, both pointers advance. Pointers wrap modulo DEPTH; level_o saturates at DEPTH by construction.
- cpu_wen_i && cpu_read_i in the same cycle is illegal; the bench asserts against it.
- Write ordering is preserved: FIFO order, with no coalescing of writes to the same address.

Decomposition:
- mapache64 package gets the VRAM region bounds as constants: PMB_BASE=12'h200, PMB_END=12'h3FF, NTBL_BASE=12'h400, NTBL_END=12'h7FF.
- mapache64 package also gets a new typedef vram_write_t = struct packed {vram_address_t address; data_t data;}.
- One sub-module: sync_fifo (DEPTH, payload type vram_write_t; push/pop/full/empty/level). The FSM, arbitration and decode stay in vram_write_scheduler.

Test Plan:
- vblank_i=0; write 0x400<-0x12, 0x7C0<-0x3F -> vram_wen_o stays 0 and level_o=2. Raise vblank_i -> vram_wen_o high for 2 consecutive cycles with 0x400/0x12 then 0x7C0/0x3F, SELECT_ntbl_o=1 on both; busy_o then falls and level_o=0.
- With DEPTH=16: 17 writes to 0x200.. during active video -> full_o=1 after the 16th write, 17th dropped, overflow_o=1. Pulse overflow_clr_i -> overflow_o=0.
- Drain of 4 entries with cpu_read_i asserted in the 2nd drain cycle at 0x205 -> that cycle vram_wen_o=0, vram_address_o=0x205, SELECT_pmb_o=1. All 4 entries are written by cycle 5, in order.
- 6 entries queued; vblank_i drops after 3 pops -> FSM returns to IDLE, level_o=3. Next vblank writes the remaining 3 in order.
- Write to 0x100 and to 0x800 -> not enqueued, level_o unchanged, overflow_o=0.
- rst asserted mid-drain with 5 entries queued -> immediately level_o=0, vram_wen_o=0, busy_o=0, and no further writes after release.
